program_loader: RTL and testbench

//   Byte-stream loader that fills Program_Memory before the CPU runs: the

---
 rtl/program_loader.sv | 128 ++++++++++++
 tb/tb_program_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: parses SYNC / length / word frames from a byte
// receiver and writes sequential Program_Memory words, releasing the CPU once complete.
module program_loader #(
  parameter int          AB   = 11,
  parameter int          DB   = 16,
  parameter logic [7:0]  SYNC = 8'h55
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          pm_we,
  output logic [AB-1:0] pm_addr,
  output logic [DB-1:0] pm_wdata,
  output logic          cpu_run,
  output logic          load_done,
  output logic          load_error
);

  localparam int unsigned DEPTH = 32'd1 << AB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_W_LO,
    S_W_HI,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_lo_q;
  logic [15:0] len_q;
  logic [7:0]  low_q;

  logic [15:0] len_full;
  logic        len_bad;
  logic        last_word;
  logic        sync_accept;
  logic        hi_accept;

  // Length is complete only while the HI length byte is on the bus.
  assign len_full = {rx_data, len_lo_q};
  assign len_bad  = (len_full == 16'd0) || (32'(len_full) > DEPTH);

  // pm_addr already holds the index of the word being completed, because the
  // post-pulse increment always lands before the next HI byte can arrive.
  assign last_word = (32'(pm_addr) == (32'(len_q) - 32'd1));

  assign sync_accept = rx_valid && (rx_data == SYNC) &&
                       ((state_q == S_IDLE) || (state_q == S_ERROR));
  assign hi_accept   = rx_valid && (state_q == S_W_HI);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring a latch.
  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      unique case (state_q)
        S_IDLE:   if (rx_data == SYNC) state_d = S_LEN_LO;
        S_LEN_LO: state_d = S_LEN_HI;
        S_LEN_HI: state_d = len_bad ? S_ERROR : S_W_LO;
        S_W_LO:   state_d = S_W_HI;
        S_W_HI:   state_d = last_word ? S_DONE : S_W_LO;
        S_DONE:   state_d = S_DONE;
        S_ERROR:  if (rx_data == SYNC) state_d = S_LEN_LO;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo_q <= '0;
      len_q    <= '0;
      low_q    <= '0;
    end else if (rx_valid) begin
      if (state_q == S_LEN_LO) len_lo_q <= rx_data;
      if (state_q == S_LEN_HI) len_q    <= len_full;
      if (state_q == S_W_LO)   low_q    <= rx_data;
    end
  end

  // Write port: pulse follows the HI byte; address advances after the pulse
  // unless that pulse wrote the final word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_we    <= 1'b0;
      pm_wdata <= '0;
      pm_addr  <= '0;
    end else begin
      pm_we <= hi_accept;
      if (hi_accept) begin
        pm_wdata <= DB'({rx_data, low_q});
      end
      if (sync_accept) begin
        pm_addr <= '0;
      end else if (pm_we && (state_q != S_DONE)) begin
        pm_addr <= pm_addr + 1'b1;
      end
    end
  end

  // Status trails DONE by one edge so cpu_run rises as the last pm_we falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_run    <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      cpu_run    <= (state_q == S_DONE);
      load_done  <= (state_q == S_DONE);
      load_error <= (state_d == S_ERROR);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame-level reference model feeds a
// scoreboard queue of expected memory writes; a monitor pops on each pm_we.
module tb_program_loader;

  localparam int         AB    = 11;
  localparam int         DB    = 16;
  localparam logic [7:0] SYNC  = 8'h55;
  localparam int         DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          pm_we;
  logic [AB-1:0] pm_addr;
  logic [DB-1:0] pm_wdata;
  logic          cpu_run;
  logic          load_done;
  logic          load_error;

  program_loader #(.AB(AB), .DB(DB), .SYNC(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .pm_we      (pm_we),
    .pm_addr    (pm_addr),
    .pm_wdata   (pm_wdata),
    .cpu_run    (cpu_run),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [DB-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every write against the scoreboard and watches the
  // cpu_run release timing relative to the final write pulse.
  logic prev_we = 1'b0;
  logic prev_run = 1'b0;
  always @(negedge clk) begin
    if (pm_we) begin
      check("pm_we expected by model", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("pm_addr", 32'(pm_addr), 32'(e.addr));
        check("pm_wdata", 32'(pm_wdata), 32'(e.data));
      end
      check("pm_we single cycle", 32'(prev_we), 32'd0);
      check("cpu_run held during write", 32'(cpu_run), 32'd0);
    end
    if (cpu_run && !prev_run) begin
      check("cpu_run rises as pm_we falls", 32'({prev_we, pm_we}), 32'b10);
    end
    prev_we  = pm_we;
    prev_run = cpu_run;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic gap(input int max_gap);
    if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " pm_we"}, 32'(pm_we), 32'd0);
    check({tag, " pm_addr"}, 32'(pm_addr), 32'd0);
    check({tag, " pm_wdata"}, 32'(pm_wdata), 32'd0);
    check({tag, " cpu_run"}, 32'(cpu_run), 32'd0);
    check({tag, " load_done"}, 32'(load_done), 32'd0);
    check({tag, " load_error"}, 32'(load_error), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    idle(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(1);
  endtask

  // Reference model: a valid frame of N words writes word k to address k.
  task automatic send_frame(input logic [15:0] words[$], input int max_gap);
    int len;
    len = words.size();
    for (int k = 0; k < len; k++) begin
      wr_t e;
      e.addr = AB'(k);
      e.data = words[k];
      exp_q.push_back(e);
    end
    send_byte(SYNC);
    check("load_error clear after SYNC", 32'(load_error), 32'd0);
    gap(max_gap);
    send_byte(8'(len));
    gap(max_gap);
    send_byte(8'(len >> 8));
    for (int k = 0; k < len; k++) begin
      gap(max_gap);
      send_byte(words[k][7:0]);
      gap(max_gap);
      send_byte(words[k][15:8]);
    end
  endtask

  task automatic send_bad(input logic [15:0] len);
    send_byte(SYNC);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    idle(3);
    check("bad len load_error", 32'(load_error), 32'd1);
    check("bad len cpu_run", 32'(cpu_run), 32'd0);
    check("bad len load_done", 32'(load_done), 32'd0);
  endtask

  task automatic expect_done(input int len);
    int i;
    for (i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    check("writes drained", 32'(exp_q.size()), 32'd0);
    idle(2);
    check("done load_done", 32'(load_done), 32'd1);
    check("done cpu_run", 32'(cpu_run), 32'd1);
    check("done load_error", 32'(load_error), 32'd0);
    check("done pm_addr stays at last", 32'(pm_addr), 32'(len - 1));
  endtask

  logic [15:0] w[$];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle(1);
    do_reset();

    // Basic two-word image.
    w = '{16'h1234, 16'h5678};
    send_frame(w, 2);
    expect_done(2);

    // Leading junk, back-to-back strobes.
    do_reset();
    send_byte(8'hAA);
    send_byte(8'h00);
    w = '{16'hBEEF};
    send_frame(w, 0);
    expect_done(1);

    // Zero length errors, then a good frame recovers.
    do_reset();
    send_bad(16'd0);
    w = '{16'h2211};
    send_frame(w, 0);
    expect_done(1);

    // Oversize length, then full-depth image.
    do_reset();
    send_bad(16'(DEPTH + 1));
    w.delete();
    for (int k = 0; k < DEPTH; k++) w.push_back(16'($urandom));
    send_frame(w, 1);
    expect_done(DEPTH);

    // Ignored bytes after DONE.
    begin
      logic [AB-1:0] addr_before;
      addr_before = pm_addr;
      send_byte(SYNC);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'hFF);
      idle(3);
      check("after done pm_addr", 32'(pm_addr), 32'(addr_before));
      check("after done load_done", 32'(load_done), 32'd1);
      check("after done cpu_run", 32'(cpu_run), 32'd1);
    end

    // Reset mid-frame after 3 of 5 words.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wr_t e;
      e.addr = AB'(k);
      e.data = 16'hA000 + 16'(k);
      exp_q.push_back(e);
    end
    send_byte(SYNC);
    send_byte(8'd5);
    send_byte(8'd0);
    for (int k = 0; k < 3; k++) begin
      send_byte(8'(k));
      send_byte(8'hA0);
    end
    idle(2);
    check("mid-frame writes seen", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    idle(1);
    rst_n = 1'b1;
    idle(1);
    w = '{16'h0F0F};
    send_frame(w, 1);
    expect_done(1);

    // Randomized frames, with junk, optional bad frame and SYNC-valued data.
    for (int it = 0; it < 8; it++) begin
      int n;
      do_reset();
      for (int j = 0; j < int'($urandom_range(3, 0)); j++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == SYNC) b = 8'hAA;
        send_byte(b);
      end
      if ($urandom_range(1, 0) == 1)
        send_bad(($urandom_range(1, 0) == 1) ? 16'd0 : 16'(DEPTH + 1 + $urandom_range(100, 0)));
      n = int'($urandom_range(16, 1));
      w.delete();
      for (int k = 0; k < n; k++)
        w.push_back(($urandom_range(3, 0) == 0) ? {SYNC, SYNC} : 16'($urandom));
      send_frame(w, int'($urandom_range(2, 0)));
      expect_done(n);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
